// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_MAX = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic               o_valid,
  output logic [IW-1:0]      o_winner
);

  int unsigned w_cand;

  // Scan from farthest to nearest so the closest requester after i_last wins.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = i_last;
    w_cand   = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_cand = (int'(i_last) + k) % NUM_REQ;
      if (i_req[w_cand]) begin
        o_valid  = 1'b1;
        o_winner = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked sharing of one fifo write port among NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned BURST_MAX = DEF_BURST_MAX,
  localparam int unsigned OW        = idx_w(NUM_REQ),
  localparam int unsigned CW        = $clog2(BURST_MAX) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  arb_state_e    r_state, w_nxt_state;
  logic [OW-1:0] r_owner, w_nxt_owner;
  logic [CW-1:0] r_beat_cnt, w_nxt_cnt;
  logic          w_accept;
  logic          w_pick_valid;
  logic [OW-1:0] w_pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (req),
    .i_last   (r_owner),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= OW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_owner    <= w_nxt_owner;
      r_beat_cnt <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_cnt   = r_beat_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_nxt_state = BURST;
          w_nxt_owner = w_pick_idx;
          w_nxt_cnt   = '0;
        end
      end
      BURST: begin
        w_accept = req[r_owner] && !fifo_full;
        if (!req[r_owner]) begin
          w_nxt_state = IDLE;
        end else if (w_accept) begin
          if (r_beat_cnt == CW'(BURST_MAX - 1)) begin
            w_nxt_state = IDLE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_beat_cnt + CW'(1);
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (w_accept) gnt[r_owner] = 1'b1;
  end

  assign fifo_wen   = w_accept;
  assign fifo_wdata = req_data[r_owner*DATA_W +: DATA_W];
  assign owner      = r_owner;
  assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter and its standalone rr_pick.
module tb_fifo_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      owner;
  logic            busy;

  logic [DW-1:0]   pdata [N];
  logic [15:0]     sb_q [$];
  int              n_checks = 0;
  int              n_fail   = 0;

  logic [N-1:0]    pk_req;
  logic [1:0]      pk_last;
  logic            pk_valid;
  logic [1:0]      pk_win;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
  end

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .owner      (owner),
    .busy       (busy)
  );

  rr_pick #(.NUM_REQ(N)) u_pick_tb (
    .i_req    (pk_req),
    .i_last   (pk_last),
    .o_valid  (pk_valid),
    .o_winner (pk_win)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard drain plus per-cycle safety properties.
  always @(negedge clk) begin
    logic [15:0] e;
    logic        bad;
    bad = (fifo_wen && fifo_full) || !$onehot0(gnt) || (!busy && fifo_wen)
       || (!rst_n && (fifo_wen || (|gnt)))
       || ((|gnt) && (gnt != (4'b0001 << owner)))
       || ((gnt & ~req) != '0)
       || (fifo_wen != (|gnt));
    chk("invariant", {31'd0, bad}, 32'd0);
    if (fifo_wen) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_owner", {30'd0, owner}, {24'd0, e[15:8]});
        chk("sb_wdata", {24'd0, fifo_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // One cycle: expectations apply to the cycle in progress; returns at posedge+1.
  task automatic tick(input string tag, input logic [N-1:0] eg, input logic eb);
    for (int i = 0; i < N; i++)
      if (eg[i]) sb_q.push_back({i[7:0], pdata[i]});
    @(negedge clk);
    chk({tag, "_gnt"},  {28'd0, gnt}, {28'd0, eg});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, "_wen"},  {31'd0, fifo_wen}, {31'd0, |eg});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (eg[i]) pdata[i] = pdata[i] + 8'h01;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", {30'd0, owner}, 32'd3);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_gnt",   {28'd0, gnt}, 32'd0);
    chk("rst_wen",   {31'd0, fifo_wen}, 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] rq;
    logic [1:0] last;
    logic       v;
    logic [1:0] w;
  } pick_vec_t;

  pick_vec_t pick_tab [8] = '{
    '{4'b0000, 2'd1, 1'b0, 2'd0}, '{4'b0001, 2'd3, 1'b1, 2'd0},
    '{4'b1111, 2'd0, 1'b1, 2'd1}, '{4'b1001, 2'd0, 1'b1, 2'd3},
    '{4'b1001, 2'd3, 1'b1, 2'd0}, '{4'b0100, 2'd2, 1'b1, 2'd2},
    '{4'b0110, 2'd1, 1'b1, 2'd2}, '{4'b1010, 2'd3, 1'b1, 2'd1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) pdata[i] = 8'(8'h10 * (i + 1));
    pk_req  = '0;
    pk_last = '0;

    // Standalone picker
    foreach (pick_tab[k]) begin
      pk_req  = pick_tab[k].rq;
      pk_last = pick_tab[k].last;
      #1;
      chk("pick_valid", {31'd0, pk_valid}, {31'd0, pick_tab[k].v});
      if (pick_tab[k].v) chk("pick_winner", {30'd0, pk_win}, {30'd0, pick_tab[k].w});
    end

    // Single producer: 4 beats, bubble, re-grant
    do_reset();
    req = 4'b0001;
    tick("t1_idle", 4'b0000, 1'b0);
    repeat (4) tick("t1_beat", 4'b0001, 1'b1);
    tick("t1_bubble", 4'b0000, 1'b0);
    tick("t1_regrant", 4'b0001, 1'b1);
    req = 4'b0000;
    tick("t1_drop", 4'b0000, 1'b1);
    tick("t1_end", 4'b0000, 1'b0);
    chk("t1_owner", {30'd0, owner}, 32'd0);

    // All requesting: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    tick("t2_idle", 4'b0000, 1'b0);
    for (int t = 0; t < 5; t++) begin
      int o;
      o = t % 4;
      repeat (4) tick("t2_beat", 4'(1 << o), 1'b1);
      chk("t2_owner", {30'd0, owner}, 32'(o));
      if (t == 4) req = 4'b0000;
      tick("t2_bubble", 4'b0000, 1'b0);
    end

    // Full stall in producer 2's burst
    do_reset();
    req = 4'b0100;
    tick("t3_idle", 4'b0000, 1'b0);
    repeat (2) tick("t3_beat", 4'b0100, 1'b1);
    fifo_full = 1'b1;
    repeat (3) tick("t3_stall", 4'b0000, 1'b1);
    fifo_full = 1'b0;
    repeat (2) tick("t3_beat", 4'b0100, 1'b1);
    req = 4'b0000;
    tick("t3_exit", 4'b0000, 1'b0);
    chk("t3_owner", {30'd0, owner}, 32'd2);

    // Producer 1 drops early, producer 2 follows
    do_reset();
    req = 4'b0110;
    tick("t4_idle", 4'b0000, 1'b0);
    repeat (2) tick("t4_p1", 4'b0010, 1'b1);
    req = 4'b0100;
    tick("t4_drop", 4'b0000, 1'b1);
    tick("t4_bubble", 4'b0000, 1'b0);
    repeat (4) tick("t4_p2", 4'b0100, 1'b1);
    req = 4'b0000;
    tick("t4_end", 4'b0000, 1'b0);

    // Reset mid-burst
    do_reset();
    req = 4'b0011;
    tick("t5_idle", 4'b0000, 1'b0);
    repeat (2) tick("t5_beat", 4'b0001, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_gnt",  {28'd0, gnt}, 32'd0);
    chk("t5_abort_wen",  {31'd0, fifo_wen}, 32'd0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_owner_rst", {30'd0, owner}, 32'd3);
    tick("t5_idle2", 4'b0000, 1'b0);
    tick("t5_p0_first", 4'b0001, 1'b1);
    req = 4'b0000;
    tick("t5_drop", 4'b0000, 1'b1);
    tick("t5_end", 4'b0000, 1'b0);

    // Full held while only producer 3 requests
    do_reset();
    fifo_full = 1'b1;
    req = 4'b1000;
    tick("t6_idle", 4'b0000, 1'b0);
    repeat (5) tick("t6_stall", 4'b0000, 1'b1);
    chk("t6_owner", {30'd0, owner}, 32'd3);
    fifo_full = 1'b0;
    repeat (4) tick("t6_beat", 4'b1000, 1'b1);
    req = 4'b0000;
    tick("t6_end", 4'b0000, 1'b0);

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
